mem_write_buffer: RTL

Write-through buffer and memory-port sequencer between the cache controller and main memory. Queues store traffic (`memWrite` pulses) in a small FIFO, drains it to memory over a req/ack handshake, and services cache read misses (`memRead`), optionally forwarding buffered store data. Decouples processor stores from memory latency and is the only master on the memory port.

---
 rtl/mem_write_buffer_pkg.sv | 21 ++
 rtl/mem_write_buffer_fifo.sv | 105 ++++++++++
 rtl/mem_write_buffer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_write_buffer_pkg.sv
// rtl/mem_write_buffer_pkg.sv - shared state codes and default sizes for the write buffer
//
// Purpose: constants shared by mem_write_buffer and wb_fifo.
//   WB_ADDR_W / WB_DATA_W / WB_DEPTH : default address width, data width, buffer entries
//   wb_state_e                       : sequencer states WB_IDLE, WB_DRAIN, WB_READ, WB_RESP
// Optional feature macro used by the bundle: WB_FWD_EN (store-to-load forwarding).

package mem_write_buffer_pkg;

  localparam int WB_ADDR_W = 16;
  localparam int WB_DATA_W = 32;
  localparam int WB_DEPTH  = 4;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_DRAIN = 2'd1,
    WB_READ  = 2'd2,
    WB_RESP  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/mem_write_buffer_fifo.sv
// rtl/mem_write_buffer_fifo.sv - store queue with registered full/empty and optional youngest-match search
//
// Purpose: circular buffer of {addr, data} store entries.
// Ports:
//   clk_i, reset_i            : clock, synchronous active-low reset
//   push_i, push_addr_i/data_i: enqueue request; ignored while full
//   pop_i                     : dequeue head; ignored while empty
//   head_addr_o, head_data_o  : oldest entry
//   full_o, empty_o           : registered status
//   lookup_addr_i, hit_o, hit_data_o : youngest matching entry (only with WB_FWD_EN)
// Macro: WB_FWD_EN adds the address comparators and lookup ports.

module wb_fifo
  import mem_write_buffer_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  // Full/empty come from the registered count, so a pop in the same cycle
  // never makes room for a push.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) tail_q <= tail_q + PW'(1);
      if (do_pop)  head_q <= head_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_mem_q[tail_q] <= push_addr_i;
      data_mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_addr_o = addr_mem_q[head_q];
  assign head_data_o = data_mem_q[head_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (addr_mem_q[head_q + PW'(i)] == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_mem_q[head_q + PW'(i)];
      end
    end
  end
`endif

endmodule

// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - write-through store buffer and memory-port sequencer
//
// Purpose: queues cache stores, drains them to memory over req/ack, and
// services read misses; sole master of the memory port.
// Ports:
//   clk, reset (sync active-low)
//   memWrite, memRead, addr, wdata : cache side requests
//   rdata, rdValid                  : read completion (one-cycle pulse)
//   wbFull, wbEmpty, wbOvf          : buffer status, wbOvf sticky on dropped store
//   memReq, memWe, memAddr, memWdata: memory request, held until memAck
//   memRdata, memAck                : memory completion
// Macro: WB_FWD_EN - forward buffered store data to reads; misses bypass the buffer.
//   Undefined: reads wait until the buffer has drained.

module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdValid,
  output logic              wbFull,
  output logic              wbEmpty,
  output logic              wbOvf,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck
);

  wb_state_e         state_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdValid_q;
  logic              wbOvf_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full, fifo_empty, fifo_pop;
`ifdef WB_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  // Acks are only meaningful while a drain is in flight; anywhere else they
  // must not pop.
  assign fifo_pop = (state_q == WB_DRAIN) && memAck;

  wb_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (memWrite),
    .push_addr_i(addr),
    .push_data_i(wdata),
    .pop_i      (fifo_pop),
    .head_addr_o(head_addr),
    .head_data_o(head_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
`ifdef WB_FWD_EN
    ,
    .lookup_addr_i(addr),
    .hit_o        (fwd_hit),
    .hit_data_o   (fwd_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= WB_IDLE;
      rdata_q    <= '0;
      rdValid_q  <= 1'b0;
      wbOvf_q    <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      if (memWrite && fifo_full) wbOvf_q <= 1'b1;

      case (state_q)
        WB_IDLE: begin
          if (memRead && memWrite) begin
            // Let the store land first; the read is decided next cycle.
            state_q <= WB_IDLE;
          end else if (memRead) begin
`ifdef WB_FWD_EN
            if (fwd_hit) begin
              rdata_q   <= fwd_data;
              rdValid_q <= 1'b1;
              state_q   <= WB_RESP;
            end else begin
              memReq_q  <= 1'b1;
              memWe_q   <= 1'b0;
              memAddr_q <= addr;
              state_q   <= WB_READ;
            end
`else
            // Drain everything ahead of the read so memory is coherent.
            if (!fifo_empty) begin
              memReq_q   <= 1'b1;
              memWe_q    <= 1'b1;
              memAddr_q  <= head_addr;
              memWdata_q <= head_data;
              state_q    <= WB_DRAIN;
            end else begin
              memReq_q  <= 1'b1;
              memWe_q   <= 1'b0;
              memAddr_q <= addr;
              state_q   <= WB_READ;
            end
`endif
          end else if (!fifo_empty) begin
            memReq_q   <= 1'b1;
            memWe_q    <= 1'b1;
            memAddr_q  <= head_addr;
            memWdata_q <= head_data;
            state_q    <= WB_DRAIN;
          end
        end
        WB_DRAIN: begin
          if (memAck) begin
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
            state_q  <= WB_IDLE;
          end
        end
        WB_READ: begin
          if (memAck) begin
            memReq_q  <= 1'b0;
            rdata_q   <= memRdata;
            rdValid_q <= 1'b1;
            state_q   <= WB_RESP;
          end
        end
        WB_RESP: begin
          rdValid_q <= 1'b0;
          state_q   <= WB_IDLE;
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign rdValid  = rdValid_q;
  assign wbFull   = fifo_full;
  assign wbEmpty  = fifo_empty;
  assign wbOvf    = wbOvf_q;
  assign memReq   = memReq_q;
  assign memWe    = memWe_q;
  assign memAddr  = memAddr_q;
  assign memWdata = memWdata_q;

endmodule
